// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg
// Shared types and helpers for the data-memory access controller:
//   state_t       - controller FSM states
//   F3_*          - RV32I load/store width codes
//   f3_legal      - is a funct3 code legal for a load or a store
//   is_misaligned - half/word access not on its natural boundary
//   align_lo      - force-aligned low address bits for an access width
package dmem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4,
        RESP = 3'd5
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        if ((f3 == F3_H) || (f3 == F3_HU))
            return lo[0];
        else if (f3 == F3_W)
            return (lo != 2'b00);
        else
            return 1'b0;
    endfunction

    function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
        if ((f3 == F3_H) || (f3 == F3_HU))
            return {lo[1], 1'b0};
        else if (f3 == F3_W)
            return 2'b00;
        else
            return lo;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit
// Combinational byte-lane steering for a little-endian 32-bit memory word.
// Ports:
//   addr_lo     in  2   byte offset within the word (already aligned for halves)
//   funct3      in  3   RV32I width/sign code
//   mem_word    in  32  word read from memory
//   store_data  in  16  right-aligned store data (byte in [7:0], half in [15:0])
//   load_val    out 32  selected lane, sign- or zero-extended
//   merged_word out 32  mem_word with the store lane(s) replaced
module dmem_lane_unit
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_word,
    input  logic [15:0] store_data,
    output logic [31:0] load_val,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  bit_base;

    always_comb begin
        bit_base = {addr_lo, 3'b000};
        byte_sel = mem_word[bit_base +: 8];
        // Halves live in lane 0 or lane 2; addr_lo[0] is ignored here.
        half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

        case (funct3)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_val = {24'h0, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_val = {16'h0, half_sel};
            default: load_val = mem_word;
        endcase

        merged_word = mem_word;
        case (funct3)
            F3_B: merged_word[bit_base +: 8] = store_data[7:0];
            F3_H: begin
                if (addr_lo[1])
                    merged_word[31:16] = store_data;
                else
                    merged_word[15:0] = store_data;
            end
            default: merged_word = mem_word;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Sequences one RV32I load/store at a time onto a word-only data memory with
// one cycle of read latency. Byte/half stores use read-modify-write.
// Optional build macro: DMEM_MISALIGN_TRAP_EN - misaligned half/word accesses
// are rejected with resp_err instead of being force-aligned.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/ready/we/funct3/addr/wdata   request handshake and payload
//   resp_valid/rdata/err            one-cycle completion pulse and result
//   mem_addr/read/write/wdata       word memory command (all registered)
//   mem_rdata                       memory read data, valid the cycle after mem_read
//
// state | meaning
// IDLE  | ready for a request; latches it on req_valid
// RD    | mem_read asserted for the target word
// CAP   | mem_rdata valid; extract load value or merge store lanes
// WR    | mem_write asserted with the full word
// ERR   | rejected request, no memory cycle
// RESP  | resp_valid pulse
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t      state;
    logic [1:0]  addr_lo_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [15:0] wdata_q;
    logic [31:0] load_val;
    logic [31:0] merged_word;
    logic        trap;
    logic [1:0]  acc_lo;

    assign acc_lo = align_lo(req_funct3, req_addr[1:0]);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Lane unit works on the live memory data during CAP.
    dmem_lane_unit u_lane (
        .addr_lo     (addr_lo_q),
        .funct3      (f3_q),
        .mem_word    (mem_rdata),
        .store_data  (wdata_q),
        .load_val    (load_val),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_lo_q  <= 2'b00;
            f3_q       <= 3'b000;
            we_q       <= 1'b0;
            wdata_q    <= 16'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_lo_q  <= acc_lo;
                        f3_q       <= req_funct3;
                        we_q       <= req_we;
                        wdata_q    <= req_wdata[15:0];
                        req_ready  <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                        mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                        if (!f3_legal(req_we, req_funct3) || trap) begin
                            state <= ERR;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                            state     <= WR;
                        end else begin
                            mem_read <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    if (we_q) begin
                        mem_wdata <= merged_word;
                        mem_write <= 1'b1;
                        state     <= WR;
                    end else begin
                        resp_rdata <= load_val;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                ERR: begin
                    resp_err   <= 1'b1;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer between the core's load/store stage and the word-only, 1-cycle-read-latency data memory. It accepts one RV32I load or store per handshake and issues the memory cycles it needs: read, read-modify-write for SB/SH, or a direct write for SW. It returns sign- or zero-extended load data or an error flag. One request is outstanding at a time; memory ports are driven only by this block.

## Interface
Parameters:
- `ADDR_W`, 32: request/memory address width.

Ports (clock and reset first):
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign code.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  request rejected, no memory write occurred.
- `mem_addr`  out  ADDR_W  word-aligned address, low 2 bits always 00.
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable, full 32-bit word.
- `mem_wdata`  out  32  word to write.
- `mem_rdata`  in  32  memory read data, valid the cycle after a `mem_read` cycle.

## Operation
- Legal codes: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores 000 SB, 001 SH, 010 SW. Any other code: `resp_err`=1, no memory access.
- Byte lanes are little-endian; byte k is in bits [8k+7:8k], selected by addr[1:0]. A half uses lane addr[1]×2.
- States:
  - IDLE: `req_ready`=1. On `req_valid`, latch addr, funct3, we, and wdata, then go to:
    - ERR if the code is illegal or the access is misaligned (macro dependent).
    - WR if SW.
    - RD otherwise.
  - RD: `mem_read`=1, then go to CAP.
  - CAP: capture `mem_rdata` into the word register. Loads: extract and extend, then go to RESP. SB/SH: merge the new lane(s) into the captured word, then go to WR.
  - WR: `mem_write`=1, `mem_wdata` = merged word (or `req_wdata` for SW), then go to RESP.
  - ERR: go to RESP with the error flag set.
  - RESP: `resp_valid`=1, then go to IDLE.
- `mem_read`, `mem_write`, `mem_addr`, and `mem_wdata` decode from registered state only. `mem_read` and `mem_write` are never high together.
- A response cannot be stalled; the requester must sample it during RESP.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- Latency counts cycles after the accept edge up to and including the RESP cycle:
  - Loads: 3 (RD, CAP, RESP).
  - SW: 2 (WR, RESP).
  - SB/SH: 4 (RD, CAP, WR, RESP).
  - Error: 2 (ERR, RESP).
- `req_ready` is low from the accept edge until the cycle after RESP. Back-to-back throughput is therefore one request per latency+1 cycles.
- Reset asserted mid-operation returns to IDLE immediately and drops `mem_write` asynchronously. A read-modify-write aborted before WR leaves the memory word unchanged.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: a misaligned access (half with addr[0]=1, word with addr[1:0]≠00) goes to ERR. `resp_err`=1, no memory cycle is issued.
- Not defined: misaligned addresses are force-aligned. A half clears addr[0]; a word clears addr[1:0]. The access proceeds normally with `resp_err`=0.

## Structure
- Package `dmem_ctrl_pkg`: state enum (IDLE, RD, CAP, WR, ERR, RESP), funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), and a legality function.
- Sub-module `dmem_lane_unit`: combinational. Given addr[1:0], funct3, the memory word, and the store data, it produces the extended load value and the merged store word.
- The FSM and latches live in `dmem_access_ctrl`.

## Test plan
- SW addr 0x10 data 0xA1B2C3D4, then LW 0x10: SW latency 2, with one `mem_write` at address 0x10; LW latency 3 returns 0xA1B2C3D4.
- After that, SB 0x13 data 0x7F, then LW 0x10: `mem_read` then `mem_write` with 0x7FB2C3D4; LW returns 0x7FB2C3D4.
- LB 0x11 returns 0xFFFFFFC3; LBU 0x11 returns 0x000000C3; LH 0x12 returns 0x00007FB2 (LHU likewise).
- funct3=011 load: `resp_err`=1 at cycle 2, with no `mem_read`/`mem_write` pulse.
- LH 0x11:
  - With macro: `resp_err`=1 and no memory access.
  - Without macro: reads word 0x10 and returns lane 0, 0xFFFFC3D4.
- SH 0x20 data 0x1234 with `rst_n` pulled low during CAP: outputs return to reset values at once; a later LW 0x20 returns the prior contents.
